eth_rx_block_lock: RTL and testbench

Receive-side 64b/66b block synchroniser and descrambler for the 10GBASE-R path. Sits between the transceiver gearbox (32-bit words plus 2-bit sync header every second word) and `eth_rx_interface`. Hunts for sync-header alignment, issuing slip pulses to the gearbox until lock, then forwards only whole, descrambled blocks. Any input word it forwards reaches the output one cycle later.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/eth_descrambler.sv | 46 ++++
 rtl/eth_rx_block_lock.sv | 175 +++++++++++++++++
 tb/tb_eth_rx_block_lock.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared types and constants for the 10GBASE-R receive path:
//                sync-header codes, block-lock FSM states, header check.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   typedef enum logic [1:0] {
      HUNT      = 2'd0,
      LOCKED    = 2'd1,
      SLIP      = 2'd2,
      SLIP_WAIT = 2'd3
   } block_lock_state_t;

   // Only the two codes with a transition between the header bits are legal.
   function automatic logic sh_is_valid(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_descrambler.sv
`default_nettype none
// ============================================================================
//  Module      : eth_descrambler
//  Description : Self-synchronising 1 + x^39 + x^58 descrambler. Output is
//                combinational; the 58-bit history of received (scrambled)
//                bits advances on every valid word.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_descrambler #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   localparam int HIST_W = 58;

   // hist_q[HIST_W-1] is the most recently received bit.
   logic [HIST_W-1:0]       hist_q, hist_d;
   logic [WIDTH+HIST_W-1:0] stream;

   // Concatenate history below the new word so bit k of the word sits at
   // stream[HIST_W+k]; taps 39 and 58 bits earlier are then plain offsets.
   always_comb begin
      stream = {i_data, hist_q};
      o_data = '0;
      for (int k = 0; k < WIDTH; k++) begin
         o_data[k] = stream[HIST_W + k] ^ stream[HIST_W + k - 39] ^ stream[k];
      end
      hist_d = i_valid ? stream[WIDTH+HIST_W-1 -: HIST_W] : hist_q;
   end

   // History register, cleared to all zeros on reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_rx_block_lock.sv
`default_nettype none
// ============================================================================
//  Module      : eth_rx_block_lock
//  Description : 64b/66b block synchroniser and descrambler. Hunts for sync
//                header alignment with slip requests to the gearbox, then
//                forwards whole descrambled blocks with one cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_block_lock
   import eth_pkg::*;
#(
   parameter int DATAPATH_WIDTH   = 32,
   parameter int SH_CNT_MAX       = 64,
   parameter int SH_INVALID_MAX   = 16,
   parameter int SLIP_WAIT_CYCLES = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [DATAPATH_WIDTH-1:0] i_data,
   input  logic                      i_data_valid,
   input  logic [1:0]                i_header,
   input  logic                      i_header_valid,
   output logic [DATAPATH_WIDTH-1:0] o_data,
   output logic                      o_data_valid,
   output logic [1:0]                o_header,
   output logic                      o_header_valid,
   output logic                      o_slip,
   output logic                      o_block_lock,
   output logic [7:0]                o_lock_loss_count
);

   localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

   block_lock_state_t         state_q, state_d;
   logic [6:0]                sh_cnt_q, sh_cnt_d, sh_cnt_inc;
   logic [4:0]                sh_invalid_cnt_q, sh_invalid_cnt_d, sh_invalid_inc;
   logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
   logic [7:0]                loss_cnt_q, loss_cnt_d;
   logic                      gate_q, gate_d;
   logic [DATAPATH_WIDTH-1:0] data_q, data_d;
   logic                      data_valid_q, data_valid_d;
   logic [1:0]                header_q, header_d;
   logic                      header_valid_q, header_valid_d;
   logic                      slip_q, slip_d;
   logic                      lock_q, lock_d;
   logic [DATAPATH_WIDTH-1:0] descr_data;
   logic                      hdr_ok;
   logic                      fwd;

   // History advances on every valid word regardless of lock state, so the
   // descrambler is already synchronised by the time lock is declared.
   eth_descrambler #(
      .WIDTH (DATAPATH_WIDTH)
   ) u_descrambler (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_data_valid),
      .i_data  (i_data),
      .o_data  (descr_data)
   );

   // Lock FSM next state, header counters, slip wait timer, loss counter.
   always_comb begin
      state_d          = state_q;
      sh_cnt_d         = sh_cnt_q;
      sh_invalid_cnt_d = sh_invalid_cnt_q;
      wait_cnt_d       = wait_cnt_q;
      loss_cnt_d       = loss_cnt_q;
      hdr_ok           = sh_is_valid(i_header);
      sh_cnt_inc       = sh_cnt_q + 7'd1;
      sh_invalid_inc   = sh_invalid_cnt_q + {4'd0, ~hdr_ok};

      case (state_q)
         HUNT: begin
            if (i_header_valid) begin
               sh_cnt_d = sh_cnt_inc;
               if (!hdr_ok) begin
                  state_d = SLIP;
               end else if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
                  state_d          = LOCKED;
                  sh_cnt_d         = '0;
                  sh_invalid_cnt_d = '0;
               end
            end
         end
         LOCKED: begin
            if (i_header_valid) begin
               sh_cnt_d         = sh_cnt_inc;
               sh_invalid_cnt_d = sh_invalid_inc;
               // Too many bad headers takes priority over window completion.
               if (sh_invalid_inc == 5'(SH_INVALID_MAX)) begin
                  state_d = SLIP;
                  if (loss_cnt_q != 8'hFF) begin
                     loss_cnt_d = loss_cnt_q + 8'd1;
                  end
               end else if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
                  sh_cnt_d         = '0;
                  sh_invalid_cnt_d = '0;
               end
            end
         end
         SLIP: begin
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
            wait_cnt_d       = WAIT_W'(SLIP_WAIT_CYCLES - 1);
            state_d          = SLIP_WAIT;
         end
         SLIP_WAIT: begin
            if (wait_cnt_q == '0) begin
               state_d = HUNT;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Forward gate is re-decided on each header from the post-header state, so
   // the locking block is forwarded and the slipping block is not.
   always_comb begin
      gate_d = gate_q;
      if (i_header_valid) begin
         gate_d = (state_d == LOCKED);
      end
      fwd            = i_data_valid & gate_d;
      data_valid_d   = fwd;
      header_valid_d = fwd & i_header_valid;
      data_d         = fwd ? descr_data : '0;
      header_d       = (fwd & i_header_valid) ? i_header : 2'b00;
      slip_d         = (state_d == SLIP);
      lock_d         = (state_d == LOCKED);
   end

   // All state and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q          <= HUNT;
         sh_cnt_q         <= '0;
         sh_invalid_cnt_q <= '0;
         wait_cnt_q       <= '0;
         loss_cnt_q       <= '0;
         gate_q           <= 1'b0;
         data_q           <= '0;
         data_valid_q     <= 1'b0;
         header_q         <= 2'b00;
         header_valid_q   <= 1'b0;
         slip_q           <= 1'b0;
         lock_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         sh_cnt_q         <= sh_cnt_d;
         sh_invalid_cnt_q <= sh_invalid_cnt_d;
         wait_cnt_q       <= wait_cnt_d;
         loss_cnt_q       <= loss_cnt_d;
         gate_q           <= gate_d;
         data_q           <= data_d;
         data_valid_q     <= data_valid_d;
         header_q         <= header_d;
         header_valid_q   <= header_valid_d;
         slip_q           <= slip_d;
         lock_q           <= lock_d;
      end
   end

   assign o_data            = data_q;
   assign o_data_valid      = data_valid_q;
   assign o_header          = header_q;
   assign o_header_valid    = header_valid_q;
   assign o_slip            = slip_q;
   assign o_block_lock      = lock_q;
   assign o_lock_loss_count = loss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_block_lock.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_rx_block_lock
//  Description : Self-checking bench for eth_rx_block_lock. Plaintext is
//                scrambled by a bit-serial reference scrambler; expected
//                outputs are queued on drive and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_block_lock;
   import eth_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_data_valid = 1'b0;
   logic [1:0]  i_header = 2'b00;
   logic        i_header_valid = 1'b0;
   logic [31:0] o_data;
   logic        o_data_valid;
   logic [1:0]  o_header;
   logic        o_header_valid;
   logic        o_slip;
   logic        o_block_lock;
   logic [7:0]  o_lock_loss_count;

   always #5 clk = ~clk;

   eth_rx_block_lock dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_data            (i_data),
      .i_data_valid      (i_data_valid),
      .i_header          (i_header),
      .i_header_valid    (i_header_valid),
      .o_data            (o_data),
      .o_data_valid      (o_data_valid),
      .o_header          (o_header),
      .o_header_valid    (o_header_valid),
      .o_slip            (o_slip),
      .o_block_lock      (o_block_lock),
      .o_lock_loss_count (o_lock_loss_count)
   );

   typedef struct {
      logic        dv;
      logic        hv;
      logic [1:0]  hdr;
      logic [31:0] data;
      logic        lock;
      logic        slip;
   } exp_t;

   typedef struct {
      logic [1:0] hdr;
      logic       slip;
   } hrow_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [57:0] scr_hist = '0;   // bit 0 = most recent scrambled bit

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every driven word's expectation is compared just after the
   // clock edge that registers it.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("data_valid", 32'(o_data_valid), 32'(e.dv));
         check("header_valid", 32'(o_header_valid), 32'(e.hv));
         check("block_lock", 32'(o_block_lock), 32'(e.lock));
         check("slip", 32'(o_slip), 32'(e.slip));
         if (e.dv) check("data", o_data, e.data);
         if (e.hv) check("header", 32'(o_header), 32'(e.hdr));
      end
   end

   // Scramble one plaintext word, drive it at the falling edge, queue expectation.
   task automatic step(input logic [31:0] plain, input logic v, input logic h,
                       input logic [1:0] hd, input logic x_fwd, input logic x_lock,
                       input logic x_slip);
      logic [31:0] s;
      logic        b;
      exp_t        e;
      s = '0;
      if (v) begin
         for (int k = 0; k < 32; k++) begin
            b        = plain[k] ^ scr_hist[38] ^ scr_hist[57];
            s[k]     = b;
            scr_hist = {scr_hist[56:0], b};
         end
      end
      @(negedge clk);
      i_data         = s;
      i_data_valid   = v;
      i_header       = hd;
      i_header_valid = h;
      e.dv   = v & x_fwd;
      e.hv   = h & x_fwd;
      e.hdr  = hd;
      e.data = plain;
      e.lock = x_lock;
      e.slip = x_slip;
      sb_q.push_back(e);
   endtask

   // Two-word block: header on the first word only.
   task automatic blk(input logic [1:0] hd, input logic x_fwd, input logic x_lock,
                      input logic x_slip);
      step($urandom, 1'b1, 1'b1, hd, x_fwd, x_lock, x_slip);
      step($urandom, 1'b1, 1'b0, hd, x_fwd, x_lock, 1'b0);
   endtask

   task automatic quiet_blocks(input int n, input logic [1:0] hd);
      for (int i = 0; i < n; i++) blk(hd, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic hunt_to_lock();
      for (int i = 1; i <= 64; i++) blk(SH_DATA, i == 64, i == 64, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1);
   end

   initial begin
      hrow_t       tbl[5];
      logic [31:0] frame[8];

      tbl[0] = '{SH_DATA, 1'b0};
      tbl[1] = '{SH_CTRL, 1'b0};
      tbl[2] = '{2'b11,   1'b1};
      tbl[3] = '{SH_CTRL, 1'b0};
      tbl[4] = '{2'b00,   1'b1};

      frame[0] = 32'h5555_5555; frame[1] = 32'hD555_5555;
      frame[2] = 32'hFFFF_FFFF; frame[3] = 32'h1100_FFFF;
      frame[4] = 32'h5544_3322; frame[5] = 32'h4500_0008;
      frame[6] = 32'h0000_2E00; frame[7] = 32'hDEAD_BEEF;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_valid", 32'(o_data_valid), 32'd0);
      check("rst_header_valid", 32'(o_header_valid), 32'd0);
      check("rst_slip", 32'(o_slip), 32'd0);
      check("rst_block_lock", 32'(o_block_lock), 32'd0);
      check("rst_loss_count", 32'(o_lock_loss_count), 32'd0);
      check("rst_data", o_data, 32'd0);
      check("rst_header", 32'(o_header), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Header classification in HUNT; the slip window ignores valid headers.
      for (int r = 0; r < 5; r++) begin
         blk(tbl[r].hdr, 1'b0, 1'b0, tbl[r].slip);
         if (tbl[r].slip) quiet_blocks(32, SH_DATA);
      end

      // Constant valid headers: lock on the 64th, that block forwarded.
      hunt_to_lock();

      // Known frame through the descrambler at one-cycle latency.
      for (int b = 0; b < 4; b++) begin
         step(frame[2*b],   1'b1, 1'b1, (b == 0) ? SH_CTRL : SH_DATA, 1'b1, 1'b1, 1'b0);
         step(frame[2*b+1], 1'b1, 1'b0, SH_DATA, 1'b1, 1'b1, 1'b0);
      end

      // Rest of window: 15 invalid headers at the end keep lock.
      for (int p = 5; p <= 64; p++) blk((p >= 50) ? 2'b11 : SH_DATA, 1'b1, 1'b1, 1'b0);

      // Next window: 16th invalid coincides with window end; slip wins.
      for (int p = 1; p <= 64; p++)
         blk((p >= 49) ? 2'b00 : SH_DATA, p != 64, p != 64, p == 64);
      check("loss_count_first", 32'(o_lock_loss_count), 32'd1);
      quiet_blocks(32, 2'b11);

      // HUNT: invalid on the 10th block, then hunt restarts from zero.
      for (int p = 1; p <= 10; p++) blk((p == 10) ? 2'b11 : SH_DATA, 1'b0, 1'b0, p == 10);
      quiet_blocks(32, 2'b00);
      hunt_to_lock();

      // Reset asserted mid-block while locked.
      step($urandom, 1'b1, 1'b1, SH_DATA, 1'b1, 1'b1, 1'b0);
      drain();
      i_data_valid   = 1'b0;
      i_header_valid = 1'b0;
      rst_n          = 1'b0;
      #1;
      check("midrst_data_valid", 32'(o_data_valid), 32'd0);
      check("midrst_header_valid", 32'(o_header_valid), 32'd0);
      check("midrst_block_lock", 32'(o_block_lock), 32'd0);
      check("midrst_loss_count", 32'(o_lock_loss_count), 32'd0);
      check("midrst_data", o_data, 32'd0);
      repeat (3) @(negedge clk);
      rst_n    = 1'b1;
      scr_hist = '0;

      // Repeated lock losses, header on every word; counter saturates at 255.
      for (int l = 1; l <= 300; l++) begin
         for (int i = 1; i <= 64; i++)
            step($urandom, 1'b1, 1'b1, SH_DATA, i == 64, i == 64, 1'b0);
         for (int i = 1; i <= 16; i++)
            step($urandom, 1'b1, 1'b1, 2'b11, i < 16, i < 16, i == 16);
         step($urandom, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
         check("loss_count_sat", 32'(o_lock_loss_count), (l > 255) ? 32'd255 : 32'(l));
         for (int i = 0; i < 64; i++)
            step($urandom, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
      end

      drain();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
